// File: rtl/motoro3_seq_pkg.sv
// rtl/motoro3_seq_pkg.sv - shared state encoding and constants for the motoro3 step sequencer
package motoro3_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RAMP = 2'd1,
      RUN  = 2'd2,
      STOP = 2'd3
   } seq_state_e;

   localparam logic [3:0] STEP_PARK  = 4'd15;
   localparam logic [3:0] STEP_LAST  = 4'd14;
   localparam int         PERIOD_MIN = 2;

endpackage

// File: rtl/motoro3_period_counter.sv
// rtl/motoro3_period_counter.sv - loadable step down-counter with period clamp and registered end-of-step strobes
module motoro3_period_counter
   import motoro3_seq_pkg::*;
#(
   parameter int CNT_W = 25
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic             active_nxt_i,
   input  logic [CNT_W-1:0] period_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             last1_o,
   output logic             last2_o,
   output logic             boundary_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] load_val;
   logic             last1_q, last2_q;

   always_comb begin
      load_val = (period_i < CNT_W'(PERIOD_MIN)) ? CNT_W'(PERIOD_MIN) : period_i;
      cnt_d    = cnt_q;
      if (load_i) begin
         cnt_d = load_val - CNT_W'(1);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // Strobes are decoded from the next count so they line up with cnt_o as registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q   <= '0;
         last1_q <= 1'b0;
         last2_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         last2_q <= (cnt_d == CNT_W'(1));
         last1_q <= active_nxt_i && (cnt_d == '0);
      end
   end

   assign cnt_o      = cnt_q;
   assign last1_o    = last1_q;
   assign last2_o    = last2_q;
   assign boundary_o = last1_q;

endmodule

// File: rtl/motoro3_step_sequencer.sv
// rtl/motoro3_step_sequencer.sv - step timebase FSM; soft-start RAMP present only with MOTORO3_SEQ_SOFTSTART_EN
module motoro3_step_sequencer
   import motoro3_seq_pkg::*;
#(
   parameter int CNT_W = 25,
   parameter int LEN_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic [CNT_W-1:0] m3r_periodInit,
   input  logic [CNT_W-1:0] m3r_periodRun,
   input  logic [CNT_W-1:0] m3r_periodDec,
   input  logic [LEN_W-1:0] m3r_plLenStart,
   input  logic [LEN_W-1:0] m3r_plLenRun,
   output logic [CNT_W-1:0] m3cnt,
   output logic             m3cntLast2,
   output logic             m3cntLast1,
   output logic [3:0]       sgStep,
   output logic [LEN_W-1:0] plLen,
   output logic             busy
);

   seq_state_e       state_q, state_d;
   logic [3:0]       step_q, step_d;
   logic [LEN_W-1:0] pllen_q, pllen_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic             busy_q;
   logic             load;
   logic             boundary;

`ifdef MOTORO3_SEQ_SOFTSTART_EN
   logic [CNT_W-1:0] ramp_p;
   // Saturate at the run period; an underflowing subtraction also lands there.
   assign ramp_p = ((m3r_periodDec > period_q) || (period_q - m3r_periodDec <= m3r_periodRun))
                   ? m3r_periodRun : (period_q - m3r_periodDec);
`else
   logic unused_cfg;
   assign unused_cfg = ^{m3r_periodInit, m3r_periodDec, m3r_plLenStart};
`endif

   always_comb begin
      state_d  = state_q;
      step_d   = step_q;
      pllen_d  = pllen_q;
      period_d = period_q;
      load     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && !stop) begin
               load     = 1'b1;
               step_d   = '0;
               state_d  = RUN;
               period_d = m3r_periodRun;
               pllen_d  = m3r_plLenRun;
`ifdef MOTORO3_SEQ_SOFTSTART_EN
               if (m3r_periodInit > m3r_periodRun) begin
                  state_d  = RAMP;
                  period_d = m3r_periodInit;
                  pllen_d  = m3r_plLenStart;
               end
`endif
            end
         end
         RAMP, RUN: begin
            if (stop && boundary) begin
               state_d  = IDLE;
               step_d   = STEP_PARK;
               pllen_d  = '0;
               period_d = '0;
            end else if (stop) begin
               state_d = STOP;
            end else if (boundary) begin
               load     = 1'b1;
               step_d   = (step_q == STEP_LAST) ? 4'd0 : step_q + 4'd1;
               state_d  = RUN;
               period_d = m3r_periodRun;
               pllen_d  = m3r_plLenRun;
`ifdef MOTORO3_SEQ_SOFTSTART_EN
               if ((state_q == RAMP) && (ramp_p != m3r_periodRun)) begin
                  state_d  = RAMP;
                  period_d = ramp_p;
                  pllen_d  = m3r_plLenStart;
               end
`endif
            end
         end
         STOP: begin
            if (boundary) begin
               state_d  = IDLE;
               step_d   = STEP_PARK;
               pllen_d  = '0;
               period_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         step_q   <= STEP_PARK;
         pllen_q  <= '0;
         period_q <= '0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         step_q   <= step_d;
         pllen_q  <= pllen_d;
         period_q <= period_d;
         busy_q   <= (state_d != IDLE);
      end
   end

   motoro3_period_counter #(.CNT_W(CNT_W)) u_period_counter (
      .clk_i        (clk),
      .rst_i        (rst),
      .load_i       (load),
      .active_nxt_i (state_d != IDLE),
      .period_i     (period_d),
      .cnt_o        (m3cnt),
      .last1_o      (m3cntLast1),
      .last2_o      (m3cntLast2),
      .boundary_o   (boundary)
   );

   assign sgStep = step_q;
   assign plLen  = pllen_q;
   assign busy   = busy_q;

endmodule

// File: doc/motoro3_step_sequencer.md
# motoro3_step_sequencer

Step sequencer for the 3-phase motor PWM path. It produces the step-period timebase (`m3cnt`, `m3cntLast1`, `m3cntLast2`), the step index `sgStep` and the per-PWM-period pulse length `plLen` consumed by `motoro3_pwm_generator`. It soft-starts the motor from an initial step period down to a target period, then holds run speed. It parks the generator in the hold step when stopped.

## Interface
Parameters:
- `CNT_W`, 25: step-period counter width.
- `LEN_W`, 16: pulse-length width.

Ports (clk and reset first):
- `clk`  in  1: system clock, 10 MHz.
- `rst`  in  1: **one clock; reset is synchronous and active-high.**
- `start`  in  1: level; sampled in IDLE.
- `stop`  in  1: level; sampled in RAMP/RUN.
- `m3r_periodInit`  in  CNT_W: first step period, in clocks.
- `m3r_periodRun`  in  CNT_W: target step period, in clocks.
- `m3r_periodDec`  in  CNT_W: period decrement applied per step boundary during RAMP.
- `m3r_plLenStart`  in  LEN_W: `plLen` value during RAMP.
- `m3r_plLenRun`  in  LEN_W: `plLen` value during RUN/STOP.
- `m3cnt`  out  CNT_W: step down-counter.
- `m3cntLast2`  out  1: high while `m3cnt==1`.
- `m3cntLast1`  out  1: high while `m3cnt==0` in an active state.
- `sgStep`  out  4: step index. Runs 0..14 when active; 15 is the park/hold value.
- `plLen`  out  LEN_W: pulse length.
- `busy`  out  1: state is not IDLE.

## Operation
- FSM states: IDLE, RAMP, RUN, STOP.
- **IDLE**
  - Outputs: `m3cnt=0`, both Last strobes 0, `sgStep=15`, `plLen=0`, `busy=0`.
  - `plLen=0` forces the generator to reload, so PWM is off.
- **IDLE exit on `start`:**
  - Load current period P=`m3r_periodInit`.
  - Go to RAMP. If `m3r_periodInit<=m3r_periodRun`, go directly to RUN with P=`m3r_periodRun`.
  - If `stop` and `start` are both high in IDLE, stay in IDLE.
- **Period clamp:** any period value below 2 is used as 2.
- **Step:** a step lasts P clocks. `m3cnt` counts P-1 down to 0, then reloads with the next P-1.
- **Step boundary:** the cycle where `m3cnt==0`. On the following cycle, `sgStep` advances 0→1→…→14→0.
- **RAMP period update:** at each boundary, newP = max(P−`m3r_periodDec`, `m3r_periodRun`).
  - Subtraction underflow yields `m3r_periodRun`.
  - When newP equals `m3r_periodRun`, the next state is RUN.
  - `m3r_periodDec=0` never leaves RAMP. This is legal; software must `stop`.
- **RUN:** P = `m3r_periodRun`, re-sampled at every boundary. Register changes take effect at the next step only.
- **STOP:**
  - Entered from RAMP or RUN when `stop` is high (priority over all other transitions).
  - The current step completes with unchanged outputs.
  - At the boundary, the next state is IDLE and all outputs return to idle values.
  - `start` is ignored while in STOP.
- **Reset mid-operation:** returns to IDLE values on the next edge. No partial-step completion.

## Timing
- All outputs are registered; every output reset value equals the IDLE value above.
- **`start` sampled high at edge t:**
  - At t+1: `busy=1`, `sgStep=0`, `m3cnt=P-1`, `plLen=m3r_plLenStart` (RAMP) or `m3r_plLenRun` (direct RUN).
- **Strobe order per step:** `m3cntLast2` one cycle, then `m3cntLast1` the next cycle. For P=2 both occur in consecutive cycles as usual.
- **`plLen` update:** changes only in the first cycle of a step, never mid-step.
- **`stop` timing:** `stop` high at edge t in step k. `sgStep` stays k through its `m3cntLast1`; IDLE values appear in the following cycle.

## Configuration
- Macro: `MOTORO3_SEQ_SOFTSTART_EN`.
- **Defined:** the RAMP state and the `m3r_periodInit`/`m3r_periodDec` logic are present as described.
- **Undefined:**
  - RAMP is removed. `start` goes directly to RUN with P=`m3r_periodRun` and `plLen=m3r_plLenRun`.
  - `m3r_periodInit`, `m3r_periodDec` and `m3r_plLenStart` are ignored.
  - Port list is unchanged.

## Structure
- Package `motoro3_seq_pkg` holds:
  - the state enum (IDLE, RAMP, RUN, STOP);
  - `STEP_PARK=4'd15`, `STEP_LAST=4'd14`, `PERIOD_MIN=2`.
- Sub-module `motoro3_period_counter`:
  - loadable CNT_W down-counter with the clamp, the `m3cntLast1`/`m3cntLast2` decode and a boundary pulse;
  - the FSM instantiates it once.

## Test plan
- **Reset:** `rst` high for 3 cycles while running → every output at its IDLE value (`sgStep=15`, `plLen=0`, `m3cnt=0`, `busy=0`) on the first edge.
- **Direct RUN:** `m3r_periodRun=10`, `start` pulse → `sgStep` 0..14 then 0, each held 10 clocks. `m3cntLast2` precedes `m3cntLast1` by 1 cycle every step.
- **Ramp** (`MOTORO3_SEQ_SOFTSTART_EN`): init=100, run=40, dec=25 → step periods 100, 75, 50, 40, 40…. `plLen` switches from `m3r_plLenStart` to `m3r_plLenRun` at the first 40-clock step.
- **Underflow/clamp:** init=30, run=1, dec=50 → periods 30, 2, 2…. RUN is entered, with no period of 0 or 1.
- **Stop:** `stop` raised in mid-step 5 of RUN → step 5 completes its full period with `m3cntLast1`, then IDLE. `start` held high during STOP causes no restart until IDLE is reached.
- **Simultaneous:** `start=stop=1` in IDLE → stays IDLE. Change `m3r_periodRun` 10→20 mid-step → the current step stays 10 and the next step is 20.
